video_timing_gen: RTL

- Raster timing generator directly upstream of the HDMI/TMDS encoder.
- Produces hsync, vsync, data-enable and pixel coordinates for one video mode. The encoder serialises the pixel stream driven by these signals.
- Runs on the board clock, qualified by a pixel clock-enable. On the 50 MHz board clock, pix_ce toggles every other cycle to give a 25 MHz pixel rate.

---
 rtl/video_timing_gen_pkg.sv | 40 ++++
 rtl/video_timing_gen_if.sv | 23 ++
 rtl/video_timing_gen_color_bar_gen.sv | 26 ++
 rtl/video_timing_gen.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared types and constants for the video timing slice: coordinates, 640x480@60 timing, colour bars.
// Optional colour-bar output is enabled by TIMING_PATTERN_EN.
package nesoi_video_pkg;

    typedef logic [11:0] coord_t;
    typedef logic [23:0] rgb_t;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
    localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
    localparam rgb_t RGB_CYAN    = 24'h00FFFF;
    localparam rgb_t RGB_GREEN   = 24'h00FF00;
    localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
    localparam rgb_t RGB_RED     = 24'hFF0000;
    localparam rgb_t RGB_BLUE    = 24'h0000FF;
    localparam rgb_t RGB_BLACK   = 24'h000000;

    // Bar 0 is the leftmost bar.
    function automatic rgb_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster output bundle from the timing generator to the TMDS encoder side.
// rgb is present only when TIMING_PATTERN_EN is defined.
interface video_timing_if;
    import nesoi_video_pkg::*;

    logic   hsync;
    logic   vsync;
    logic   de;
    coord_t x;
    coord_t y;
    logic   line_start;
    logic   frame_start;
`ifdef TIMING_PATTERN_EN
    rgb_t   rgb;

    modport master (output hsync, vsync, de, x, y, line_start, frame_start, rgb);
    modport slave  (input  hsync, vsync, de, x, y, line_start, frame_start, rgb);
`else
    modport master (output hsync, vsync, de, x, y, line_start, frame_start);
    modport slave  (input  hsync, vsync, de, x, y, line_start, frame_start);
`endif

endinterface

// File: rtl/video_timing_gen_color_bar_gen.sv
// Combinational eight-bar colour pattern from the horizontal position; black outside the active region.
// Registered by the parent alongside de, so no latency of its own.
module color_bar_gen
    import nesoi_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE
) (
    input  coord_t x,
    input  logic   de,
    output rgb_t   rgb
);

    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    coord_t     bar_idx;
    logic [2:0] bar_sel;

    assign bar_idx = x / coord_t'(BAR_W);

    // A ragged last bar (H_ACTIVE not a multiple of 8) stays black rather than wrapping to white.
    always_comb begin
        bar_sel = (bar_idx > coord_t'(7)) ? 3'd7 : bar_idx[2:0];
        rgb     = de ? bar_color(bar_sel) : RGB_BLACK;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: hsync/vsync/de/coordinates registered one clk after each pix_ce; holds when pix_ce=0.
// Optional colour-bar rgb output under TIMING_PATTERN_EN.
module video_timing_gen
    import nesoi_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_ce,
    video_timing_if.master vid
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_cfg_check
        $error("video_timing_gen: H_TOTAL/V_TOTAL exceed the 12-bit counter range");
    end

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   de_q, de_d;
    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   line_start_q, line_start_d;
    logic   frame_start_q, frame_start_d;

    logic de_now;
    logic in_hsync;
    logic in_vsync;

    // Decode of the pixel about to be presented (pre-increment counters).
    assign de_now   = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    assign in_hsync = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign in_vsync = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        if (pix_ce) begin
            hsync_d       = in_hsync ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = in_vsync ? VSYNC_POL : ~VSYNC_POL;
            de_d          = de_now;
            x_d           = h_cnt_q;
            y_d           = v_cnt_q;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;

`ifdef TIMING_PATTERN_EN
    rgb_t bar_rgb;
    rgb_t rgb_q, rgb_d;

    color_bar_gen #(.H_ACTIVE(H_ACTIVE)) u_color_bar_gen (
        .x   (h_cnt_q),
        .de  (de_now),
        .rgb (bar_rgb)
    );

    always_comb begin
        rgb_d = rgb_q;
        if (pix_ce) begin
            rgb_d = bar_rgb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign vid.rgb = rgb_q;
`endif

endmodule
